// File: rtl/ras.sv
// Return address stack for the fetch predictor stage.
// Circular buffer of link targets with a top pointer and a saturating valid count.
module ras #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        link_valid_in,
  input  logic [RAS_TARGET_WIDTH-1:0] link_target_in,
  input  logic                        ret_valid_in,
  input  logic                        update_valid_in,
  input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index_in,
  input  logic [RAS_INDEX_WIDTH:0]    update_ras_count_in,
  output logic [RAS_TARGET_WIDTH-1:0] ras_ret_target_out,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index_out,
  output logic [RAS_INDEX_WIDTH:0]    ras_count_out,
  output logic                        ras_empty_out
);

  localparam logic [RAS_INDEX_WIDTH-1:0] IDX_ONE  = RAS_INDEX_WIDTH'(1);
  localparam logic [RAS_INDEX_WIDTH:0]   CNT_ONE  = (RAS_INDEX_WIDTH+1)'(1);
  localparam logic [RAS_INDEX_WIDTH:0]   CNT_FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] r_stack [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  r_idx;
  logic [RAS_INDEX_WIDTH:0]    r_count;

  logic [RAS_INDEX_WIDTH-1:0]  w_idx_inc;
  logic [RAS_INDEX_WIDTH-1:0]  w_idx_dec;
  logic                        w_empty;

  assign w_idx_inc = r_idx + IDX_ONE;
  assign w_idx_dec = r_idx - IDX_ONE;
  assign w_empty   = (r_count == '0);

  // Restore beats push/pop; push+pop together rewrites the top in place.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) r_stack[i] <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else if (update_valid_in) begin
      r_idx   <= update_ras_index_in;
      r_count <= update_ras_count_in;
    end else if (link_valid_in && ret_valid_in) begin
      r_stack[r_idx] <= link_target_in;
    end else if (link_valid_in) begin
      r_stack[w_idx_inc] <= link_target_in;
      r_idx              <= w_idx_inc;
      if (r_count != CNT_FULL) r_count <= r_count + CNT_ONE;
    end else if (ret_valid_in && !w_empty) begin
      r_idx   <= w_idx_dec;
      r_count <= r_count - CNT_ONE;
    end
  end

  assign ras_ret_target_out = r_stack[r_idx];
  assign ras_index_out      = r_idx;
  assign ras_count_out      = r_count;
  assign ras_empty_out      = w_empty;

endmodule
